// File: rtl/dmem_arbiter.sv
// Purpose: shares one single-port data memory between the MEM pipeline stage and an auxiliary requester.
// Latency: pipeline access takes at least 2 cycles (IDLE, then PIPE ack); an aux completion pulses aux_done_o one cycle after its ack.
// Backpressure: stall_o holds the pipeline until its PIPE access acks; aux holds its request until aux_done_o; memory stretches via mem_ack_i.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   MemRead_i/MemWrite_i/Address_i/Write_data_i -> stall_o, Read_data_o   pipeline side
//   aux_req_i/aux_we_i/aux_addr_i/aux_wdata_i   -> aux_gnt_o, aux_done_o, aux_rdata_o   auxiliary side
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o   <- mem_ack_i, mem_rdata_i   memory side
module dmem_arbiter #(
    parameter int MAX_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_data_i,
    output logic        stall_o,
    output logic [31:0] Read_data_o,
    input  logic        aux_req_i,
    input  logic        aux_we_i,
    input  logic [31:0] aux_addr_i,
    input  logic [31:0] aux_wdata_i,
    output logic        aux_gnt_o,
    output logic        aux_done_o,
    output logic [31:0] aux_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    // Counter must hold the value MAX_STREAK itself; keep at least one bit.
    localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PIPE = 2'd1,
        AUX  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [SW-1:0] r_streak;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [31:0]   r_read_data;
    logic          r_aux_done;
    logic [31:0]   r_aux_rdata;

    logic          w_pipe_pend;
    logic          w_aux_elig;
    logic          w_aux_priority;
    logic          w_grant_pipe;
    logic          w_grant_aux;
    logic          w_pipe_ack;
    logic          w_aux_ack;
    logic          w_pipe_rd_ack;

    assign w_pipe_pend    = MemRead_i | MemWrite_i;
    // The done pulse doubles as a one-cycle cooldown so a held request is not regranted at once.
    assign w_aux_elig     = aux_req_i & ~r_aux_done;
    // Aux overrides the pipeline only after MAX_STREAK pipeline grants made it wait.
    assign w_aux_priority = w_aux_elig & (r_streak == STREAK_MAX);

    assign w_pipe_ack     = (r_state == PIPE) & mem_ack_i;
    assign w_aux_ack      = (r_state == AUX) & mem_ack_i;
    assign w_pipe_rd_ack  = w_pipe_ack & ~r_mem_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_pipe = 1'b0;
        w_grant_aux  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pipe_pend && !w_aux_priority) begin
                    w_next_state = PIPE;
                    w_grant_pipe = 1'b1;
                end else if (w_aux_elig) begin
                    w_next_state = AUX;
                    w_grant_aux  = 1'b1;
                end
            end
            PIPE, AUX: begin
                if (mem_ack_i) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_read_data <= 32'd0;
            r_aux_done  <= 1'b0;
            r_aux_rdata <= 32'd0;
            r_streak    <= '0;
        end else begin
            // Memory operands are captured once at grant and held for the whole access.
            if (w_grant_pipe) begin
                r_mem_we    <= MemWrite_i;
                r_mem_addr  <= Address_i;
                r_mem_wdata <= Write_data_i;
            end else if (w_grant_aux) begin
                r_mem_we    <= aux_we_i;
                r_mem_addr  <= aux_addr_i;
                r_mem_wdata <= aux_wdata_i;
            end

            if (w_pipe_rd_ack) begin
                r_read_data <= mem_rdata_i;
            end

            r_aux_done <= w_aux_ack;
            if (w_aux_ack && !r_mem_we) begin
                r_aux_rdata <= mem_rdata_i;
            end

            if (w_grant_aux) begin
                r_streak <= '0;
            end else if ((r_state == IDLE) && !aux_req_i) begin
                r_streak <= '0;
            end else if (w_grant_pipe && aux_req_i && (r_streak != STREAK_MAX)) begin
                r_streak <= r_streak + SW'(1);
            end
        end
    end

    assign mem_req_o   = (r_state == PIPE) | (r_state == AUX);
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    // Only a PIPE ack releases the pipeline; an aux access in flight keeps it frozen.
    assign stall_o     = ~rst & w_pipe_pend & ~w_pipe_ack;
    // Load data is forwarded in the ack cycle so MEM_WB can capture it at that edge.
    assign Read_data_o = w_pipe_rd_ack ? mem_rdata_i : r_read_data;

    assign aux_gnt_o   = (r_state == AUX);
    assign aux_done_o  = r_aux_done;
    assign aux_rdata_o = r_aux_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: self-checking bench for dmem_arbiter with a latency-programmable memory model and scoreboards.
// Latency: memory acks mem_lat cycles after mem_req_o rises (0 = same cycle).
// Backpressure: pipeline driver holds its request while stall_o is high; aux driver holds until aux_done_o.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] Address_i, Write_data_i;
    logic        stall_o;
    logic [31:0] Read_data_o;
    logic        aux_req_i, aux_we_i;
    logic [31:0] aux_addr_i, aux_wdata_i;
    logic        aux_gnt_o, aux_done_o;
    logic [31:0] aux_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .Address_i(Address_i), .Write_data_i(Write_data_i),
        .stall_o(stall_o), .Read_data_o(Read_data_o),
        .aux_req_i(aux_req_i), .aux_we_i(aux_we_i),
        .aux_addr_i(aux_addr_i), .aux_wdata_i(aux_wdata_i),
        .aux_gnt_o(aux_gnt_o), .aux_done_o(aux_done_o), .aux_rdata_o(aux_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];
    int          mem_lat;
    int          wait_cnt = 0;
    logic        ack_force;
    logic        mem_load;

    assign mem_ack_i   = ack_force | (mem_req_o && (wait_cnt >= mem_lat));
    assign mem_rdata_i = mem[mem_addr_o[9:2]];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
        end else if (mem_req_o && mem_ack_i && mem_we_o) begin
            mem[mem_addr_o[9:2]] <= mem_wdata_o;
        end
        if (!mem_req_o || mem_ack_i) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    // ---------------- scoreboards ----------------
    logic [63:0] exp_rd_q  [$];   // pipeline load data
    logic [63:0] exp_pwr_q [$];   // pipeline stores {addr,data}
    logic [63:0] exp_awr_q [$];   // aux stores {addr,data}
    logic [63:0] exp_aux_q [$];   // aux completions {is_read,data}
    bit          grant_log [$];   // 0 = PIPE grant, 1 = AUX grant
    logic [31:0] last_rd_exp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic        prev_req = 1'b0;
    logic [63:0] mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_req = 1'b0;
        end else begin
            if (mem_req_o && !prev_req) grant_log.push_back(aux_gnt_o);
            prev_req = mem_req_o;
            if (aux_gnt_o && (MemRead_i || MemWrite_i)) chk_eq("stall_during_aux", 64'(stall_o), 64'd1);
            if (mem_req_o && mem_ack_i) begin
                if (aux_gnt_o) begin
                    if (mem_we_o) begin
                        if (exp_awr_q.size() == 0) chk_eq("aux_wr_unexpected", 64'd1, 64'd0);
                        else begin
                            mon_e = exp_awr_q.pop_front();
                            chk_eq("aux_wr_addr_data", {mem_addr_o, mem_wdata_o}, mon_e);
                        end
                    end
                end else begin
                    chk_eq("stall_at_pipe_ack", 64'(stall_o), 64'd0);
                    if (mem_we_o) begin
                        chk_eq("rdata_hold_on_store", 64'(Read_data_o), 64'(last_rd_exp));
                        if (exp_pwr_q.size() == 0) chk_eq("pipe_wr_unexpected", 64'd1, 64'd0);
                        else begin
                            mon_e = exp_pwr_q.pop_front();
                            chk_eq("pipe_wr_addr_data", {mem_addr_o, mem_wdata_o}, mon_e);
                        end
                    end else begin
                        if (exp_rd_q.size() == 0) chk_eq("pipe_rd_unexpected", 64'd1, 64'd0);
                        else begin
                            mon_e = exp_rd_q.pop_front();
                            chk_eq("pipe_rdata", 64'(Read_data_o), mon_e);
                        end
                    end
                end
            end
            if (aux_done_o) begin
                if (exp_aux_q.size() == 0) chk_eq("aux_done_unexpected", 64'd1, 64'd0);
                else begin
                    mon_e = exp_aux_q.pop_front();
                    if (mon_e[32]) chk_eq("aux_rdata", 64'(aux_rdata_o), {32'd0, mon_e[31:0]});
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic pipe_access(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, output int stalls);
        int idx;
        bit done;
        idx = int'(addr[9:2]);
        MemRead_i = rd; MemWrite_i = wr; Address_i = addr; Write_data_i = data;
        if (wr) begin
            exp_pwr_q.push_back({addr, data});
            ref_mem[idx] = data;
        end else begin
            exp_rd_q.push_back({32'd0, ref_mem[idx]});
            last_rd_exp = ref_mem[idx];
        end
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            else done = 1'b1;
        end
        if (!done) chk_eq("pipe_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
    endtask

    task automatic wait_aux_done();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (aux_done_o) done = 1'b1;
        end
        if (!done) chk_eq("aux_timeout", 64'd1, 64'd0);
    endtask

    task automatic aux_access(input logic we, input logic [31:0] addr, input logic [31:0] data);
        int idx;
        idx = int'(addr[9:2]);
        aux_req_i = 1'b1; aux_we_i = we; aux_addr_i = addr; aux_wdata_i = data;
        if (we) begin
            exp_awr_q.push_back({addr, data});
            exp_aux_q.push_back(64'd0);
            ref_mem[idx] = data;
        end else begin
            exp_aux_q.push_back({31'd0, 1'b1, ref_mem[idx]});
        end
        wait_aux_done();
        @(posedge clk); #1;
        aux_req_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int          st, st5;
    logic [6:0]  seq;
    bit          got;

    initial begin
        rst = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        Address_i = 32'd0; Write_data_i = 32'd0;
        aux_req_i = 1'b0; aux_we_i = 1'b0; aux_addr_i = 32'd0; aux_wdata_i = 32'd0;
        ack_force = 1'b0; mem_lat = 1; mem_load = 1'b1; last_rd_exp = 32'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = (32'(i) * 32'h0100_0193) ^ 32'h5A5A_0000;
        ref_mem[16]  = 32'hDEAD_BEEF;
        ref_mem[128] = 32'hCAFE_F00D;

        // Reset values, with a pipeline request present to show stall_o is forced low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_stall", 64'(stall_o), 64'd0);
        chk_eq("rst_mem_req_we", {62'd0, mem_req_o, mem_we_o}, 64'd0);
        chk_eq("rst_aux_gnt_done", {62'd0, aux_gnt_o, aux_done_o}, 64'd0);
        chk_eq("rst_mem_addr_wdata", {mem_addr_o, mem_wdata_o}, 64'd0);
        chk_eq("rst_rdata", {Read_data_o, aux_rdata_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; MemRead_i = 1'b0; mem_load = 1'b0;

        // Load, ack one cycle after request: two stall cycles.
        mem_lat = 1;
        pipe_access(1'b1, 1'b0, 32'h40, 32'd0, st);
        chk_eq("load_stall_cycles", 64'(st), 64'd2);
        @(negedge clk);
        chk_eq("load_req_drops", 64'(mem_req_o), 64'd0);
        chk_eq("load_rdata_held", 64'(Read_data_o), 64'hDEAD_BEEF);

        // Store, ack in the request cycle: one stall cycle.
        mem_lat = 0;
        @(posedge clk); #1;
        pipe_access(1'b0, 1'b1, 32'h10, 32'h1234_5678, st);
        chk_eq("store_stall_cycles", 64'(st), 64'd1);
        pipe_access(1'b1, 1'b0, 32'h10, 32'd0, st);
        // MemRead and MemWrite together: the store wins.
        pipe_access(1'b1, 1'b1, 32'h14, 32'hA5A5_5A5A, st);
        pipe_access(1'b1, 1'b0, 32'h14, 32'd0, st);

        // Aux and load arrive together with streak 0: pipeline first, then aux.
        mem_lat = 1;
        grant_log.delete();
        fork
            pipe_access(1'b1, 1'b0, 32'h40, 32'd0, st);
            aux_access(1'b0, 32'h200, 32'd0);
        join
        @(negedge clk);
        chk_eq("aux_done_one_cycle", 64'(aux_done_o), 64'd0);
        chk_eq("pa_grant_count", 64'(grant_log.size()), 64'd2);
        seq = '0;
        for (int i = 0; i < grant_log.size() && i < 7; i++) seq[i] = grant_log[i];
        chk_eq("pa_grant_order", 64'(seq), 64'b10);

        // Streak limit: four pipeline grants, then aux, then pipeline resumes.
        @(posedge clk); #1;
        grant_log.delete();
        st5 = 0;
        fork
            aux_access(1'b0, 32'h204, 32'd0);
            begin
                for (int k = 0; k < 6; k++) begin
                    pipe_access(1'b1, 1'b0, 32'h100 + 32'(k * 4), 32'd0, st);
                    if (k == 4) st5 = st;
                end
            end
        join
        chk_eq("streak_grant_count", 64'(grant_log.size()), 64'd7);
        seq = '0;
        for (int i = 0; i < grant_log.size() && i < 7; i++) seq[i] = grant_log[i];
        chk_eq("streak_grant_order", 64'(seq), 64'b0010000);
        chk_eq("streak_blocked_load_stalls", 64'(st5), 64'd5);

        // Aux request held through done: no grant in the done cycle, regrant after the cooldown.
        @(posedge clk); #1;
        aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h208; aux_wdata_i = 32'd0;
        exp_aux_q.push_back({31'd0, 1'b1, ref_mem[130]});
        wait_aux_done();
        chk_eq("no_regrant_in_done", {62'd0, aux_gnt_o, mem_req_o}, 64'd0);
        @(posedge clk); #1;
        exp_aux_q.push_back({31'd0, 1'b1, ref_mem[130]});
        @(negedge clk);
        chk_eq("cooldown_gap", 64'(aux_gnt_o), 64'd0);
        @(negedge clk);
        chk_eq("regrant_after_done", 64'(aux_gnt_o), 64'd1);
        wait_aux_done();
        @(posedge clk); #1;
        aux_req_i = 1'b0;

        // Mixed random traffic with disjoint pipeline / aux address windows.
        for (int i = 0; i < 16; i++) begin
            logic w;
            mem_lat = int'($urandom_range(0, 2));
            w = 1'($urandom_range(0, 1));
            fork
                pipe_access(~w, w, 32'(($urandom_range(0, 63)) * 4), $urandom, st);
                begin
                    if (i % 4 == 0)
                        aux_access(1'($urandom_range(0, 1)), 32'h300 + 32'(($urandom_range(0, 31)) * 4), $urandom);
                end
            join
        end

        // Reset mid aux access; a late ack must not complete anything.
        mem_lat = 1000;
        @(posedge clk); #1;
        aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h240;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            if (aux_gnt_o) got = 1'b1;
        end
        if (!got) chk_eq("abort_setup_timeout", 64'd1, 64'd0);
        MemRead_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk_eq("abort_ctrl_zero", {59'd0, stall_o, mem_req_o, mem_we_o, aux_gnt_o, aux_done_o}, 64'd0);
        chk_eq("abort_addr_wdata_zero", {mem_addr_o, mem_wdata_o}, 64'd0);
        chk_eq("abort_rdata_zero", {Read_data_o, aux_rdata_o}, 64'd0);
        @(posedge clk); #1;
        aux_req_i = 1'b0; MemRead_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd_exp = 32'd0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            ack_force = (c == 1);
            @(negedge clk);
            chk_eq("abort_no_done_idle", {62'd0, aux_done_o, mem_req_o}, 64'd0);
        end
        @(posedge clk); #1;
        ack_force = 1'b0;
        mem_lat = 1;
        pipe_access(1'b1, 1'b0, 32'h40, 32'd0, st);
        chk_eq("recover_load_stalls", 64'(st), 64'd2);

        repeat (3) @(posedge clk);
        chk_eq("rd_q_drained", 64'(exp_rd_q.size()), 64'd0);
        chk_eq("wr_q_drained", 64'(exp_pwr_q.size() + exp_awr_q.size()), 64'd0);
        chk_eq("aux_q_drained", 64'(exp_aux_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4: maximum consecutive pipeline grants while an aux request waits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 MemRead_i  input  1  MEM-stage read request, held by pipeline while stall_o high.
REQ-005 MemWrite_i  input  1  MEM-stage write request, held likewise.
REQ-006 Address_i  input  32  MEM-stage byte address.
REQ-007 Write_data_i  input  32  MEM-stage store data.
REQ-008 stall_o  output  1  freeze PC/IF_ID/ID_EX/EX_MEM this cycle.
REQ-009 Read_data_o  output  32  load data to MEM_WB.
REQ-010 aux_req_i, aux_we_i  input  1 each  auxiliary requester request / write-enable.
REQ-011 aux_addr_i, aux_wdata_i  input  32 each  auxiliary address / write data.
REQ-012 aux_gnt_o  output  1  auxiliary access in progress.
REQ-013 aux_done_o  output  1  one-cycle completion pulse for auxiliary access.
REQ-014 aux_rdata_o  output  32  auxiliary read data.
REQ-015 mem_req_o, mem_we_o  output  1 each  request / write to single-port data memory.
REQ-016 mem_addr_o, mem_wdata_o  output  32 each  memory address / write data.
REQ-017 mem_ack_i  input  1  memory completes access this cycle (any latency >= 0 cycles after mem_req_o rises).
REQ-018 mem_rdata_i  input  32  memory read data, valid when mem_ack_i high.

Function
REQ-019 FSM states IDLE, PIPE, AUX; pipe_pend = MemRead_i | MemWrite_i.
REQ-020 IDLE: pipe_pend and not (aux eligible and streak == MAX_STREAK) -> PIPE; else aux eligible -> AUX; else stay.
REQ-021 Aux eligible = aux_req_i high and aux_done_o low (one-cycle cooldown after each aux completion).
REQ-022 On entering PIPE/AUX, mem_addr_o, mem_wdata_o, mem_we_o registered from the winning requester; mem_req_o high for the whole PIPE/AUX state.
REQ-023 Pipeline write selected when MemWrite_i high (MemWrite_i wins if both MemRead_i and MemWrite_i high).
REQ-024 PIPE or AUX with mem_ack_i high -> IDLE at next edge; mem_ack_i in IDLE ignored.
REQ-025 stall_o = pipe_pend and not (state == PIPE and mem_ack_i); minimum pipeline access = 2 cycles (1 stall cycle).
REQ-026 Read_data_o = mem_rdata_i in PIPE-ack cycle of a read; otherwise holds last pipeline read value.
REQ-027 aux_gnt_o high exactly while state == AUX.
REQ-028 aux_done_o registered: high for one cycle after the AUX-ack cycle; aux_rdata_o latched from mem_rdata_i at same edge (reads only), held until next aux read.
REQ-029 Aux requester holds aux_req_i and its operands from request until aux_done_o.
REQ-030 Streak counter (width clog2(MAX_STREAK+1)): +1 on each PIPE grant while aux_req_i high, saturating at MAX_STREAK; cleared on AUX grant or any IDLE cycle with aux_req_i low.
REQ-031 Aux access in progress with pipe_pend high keeps stall_o high until AUX completes and a subsequent PIPE acks.

Reset
REQ-032 rst high: state IDLE, mem_req_o, mem_we_o, aux_gnt_o, aux_done_o 0; mem_addr_o, mem_wdata_o, Read_data_o, aux_rdata_o 0; streak 0; stall_o forced 0.
REQ-033 rst asserted mid-access aborts it immediately; a late mem_ack_i after release is ignored; no aux_done_o generated for the aborted access.

Verification
REQ-034 MemRead_i=1, Address_i=0x40, ack 1 cycle after mem_req_o, mem_rdata_i=0xDEADBEEF -> stall_o high 2 cycles, Read_data_o=0xDEADBEEF in ack cycle, mem_req_o drops next cycle.
REQ-035 MemWrite_i=1, Address_i=0x10, Write_data_i=0x12345678, ack same cycle as mem_req_o -> mem_we_o=1, mem_wdata_o=0x12345678, stall_o high exactly 1 cycle.
REQ-036 aux_req_i and MemRead_i rise same cycle, streak 0 -> PIPE first; aux granted in next IDLE only if pipe_pend low, aux_done_o pulses 1 cycle, aux_rdata_o correct.
REQ-037 Continuous pipeline loads with aux_req_i held high, MAX_STREAK=4 -> exactly 4 PIPE grants, then AUX grant with stall_o high, then PIPE resumes.
REQ-038 aux_req_i held high through aux_done_o -> no regrant in done cycle; regrant the cycle after.
REQ-039 rst pulsed while in AUX before ack, ack arrives 2 cycles later -> all outputs 0 during rst, no aux_done_o, state IDLE, ack ignored.
